spi_relay_bridge: RTL
=====================

# spi_relay_bridge

Clocked, parametrised successor to the sniff-and-forward SPI path: passively captures words from the shared sensor SPI bus (slave side), buffers them in a FIFO and re-emits each word as its own SPI-master frame toward the Pi. Unlike the unclocked deserializer/serializer pair, it supports:
- configurable word width and words per chip-select frame (channels);
- buffering with overflow/framing error reporting;
- a parallel tap for the filter stage.

## Interface
Parameters:
- WORD_W, 16, bits per word.
- NUM_CH, 1, words per input CS frame; channel index = position in frame. CH_W = max(1, $clog2(NUM_CH)).
- FIFO_DEPTH, 8, FIFO entries; must be a power of 2, ≥2.
- CLK_DIV, 4, clk cycles per out_sck half-period; ≥2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_sck  in  1  sniffed bus clock (async).
- in_cs_n  in  1  sniffed chip select, active-low (async).
- in_miso  in  1  sniffed sensor data (async).
- out_sck  out  1  relay SPI clock, mode 0.
- out_cs_n  out  1  relay chip select, active-low.
- out_mosi  out  1  relay data, MSB first.
- tap_data  out  WORD_W  last captured word.
- tap_ch  out  CH_W  channel of tap_data.
- tap_valid  out  1  one-cycle pulse per captured word.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- ovf  out  1  sticky: word dropped because FIFO was full.
- frame_err  out  1  sticky: partial word at CS rise, or more than NUM_CH words in a frame.
- err_clr  in  1  synchronous clear of ovf and frame_err.

## Operation
- **RX front end.** in_sck, in_cs_n and in_miso pass through 2-flop synchronisers plus one history flop. Requirement: in_sck ≤ clk/4.
- **Framing.** Synchronised in_cs_n falling edge resets the bit counter and channel counter.
- **Sampling.** Each synchronised in_sck rising edge while CS is low shifts in_miso in MSB first. When WORD_W bits are collected:
  - tap_data/tap_ch update and tap_valid pulses;
  - the word and its channel are pushed to the FIFO;
  - the channel counter increments.
- **Framing errors.**
  - CS rises with bit count ≠ 0: partial word discarded, frame_err set.
  - Word completes with channel counter = NUM_CH: word not tapped or pushed, frame_err set.
- **FIFO full.** Push while full with no pop: word dropped, ovf set. Push and pop in the same cycle when full: both succeed, level unchanged.
- **err_clr.** Clears ovf and frame_err. If an error event occurs in the same cycle as err_clr, the error event wins.
- **TX state machine.**
  - IDLE: if FIFO not empty, pop the word, load the shift register, drive out_cs_n low, go to SETUP.
  - SETUP: out_mosi = MSB; wait CLK_DIV; go to HI.
  - HI: out_sck = 1; wait CLK_DIV; go to LO.
  - LO: out_sck = 0; shift so the next bit is on out_mosi. Go to HI if bits remain, else HOLD.
  - HOLD: wait CLK_DIV; drive out_cs_n high; go to GAP.
  - GAP: wait 2·CLK_DIV; go to IDLE.
- **Reset.** Reset at any point (mid-frame included) returns everything to reset values and empties the FIFO. There is no partial-frame completion after reset.
- **Reset values.** out_sck=0, out_cs_n=1, out_mosi=0, tap_data=0, tap_ch=0, tap_valid=0, fifo_level=0, ovf=0, frame_err=0; TX in IDLE.

## Timing
- **RX latency.** Let clk edge N be the first to sample the final in_sck rise high. tap_valid is high in the cycle after edge N+2; fifo_level increments at the same edge.
- **TX start.** A word in a previously empty FIFO causes out_cs_n to fall one cycle after fifo_level becomes nonzero.
- **TX frame.** From out_cs_n falling to rising: CLK_DIV·(2·TX_BITS+2) clk cycles. Minimum CS-high gap: 2·CLK_DIV cycles.
- **Relay data timing.** out_mosi changes only on out_sck falling edges or in SETUP. It is stable for ≥CLK_DIV cycles around each rising edge.
- **Registers.** All outputs are registered.

## Configuration
- SPI_RELAY_CHTAG_EN defined:
  - TX_BITS = CH_W + WORD_W;
  - each relay frame carries the channel index (MSB first), followed by the word.
- Undefined: TX_BITS = WORD_W, and the channel is only visible on tap_ch.
- The RX side and tap are identical in both builds.

## Structure
- Package spi_relay_pkg holds:
  - tx_state_t enum (IDLE, SETUP, HI, LO, HOLD, GAP);
  - the ch_width(NUM_CH) function;
  - the synchroniser depth localparam (2).
- Sub-module spi_word_fifo:
  - parametrised by width (WORD_W+CH_W) and depth;
  - synchronous, registered level, async active-low reset.
- RX capture and TX engine stay in the top of the block.

## Test plan
- **Single word.** Defaults; one CS frame carrying 0xA5C3 at clk/8 → one tap_valid with tap_data=0xA5C3, tap_ch=0. The relay frame shows 16 out_sck pulses and MOSI bits 1010_0101_1100_0011. CS-low duration is 136 clk cycles.
- **Multi-channel.** NUM_CH=3; one frame with 0x0001, 0x0002, 0x0003 → tap_ch 0, 1, 2 in order and three separate relay frames. A fourth word in the frame → frame_err=1, level unchanged.
- **Partial word.** in_cs_n rises after 9 bits → no tap_valid, frame_err=1, and no relay frame. err_clr → frame_err=0.
- **Overflow.** FIFO_DEPTH=4 with the relay stalled by a long GAP: 6 back-to-back words → ovf=1 and level saturates at 4. Relayed data is the first words in order, with dropped words absent.
- **Channel tag.** SPI_RELAY_CHTAG_EN, NUM_CH=4, word 0xFFFF on channel 2 → 18-bit frame 10_1111111111111111.
- **Reset mid-operation.** rst_n low mid-relay-frame → out_cs_n=1, out_sck=0, fifo_level=0 immediately. Nothing is emitted after release until new input arrives.

Source files
------------

// File: rtl/spi_relay_pkg.sv
// Shared types and helpers for the SPI relay bridge: TX state encoding,
// channel-index width helper and synchroniser depth.
package spi_relay_pkg;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SETUP,
    TX_HI,
    TX_LO,
    TX_HOLD,
    TX_GAP
  } tx_state_t;

  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_word_fifo.sv
// Synchronous FIFO holding {channel, word} entries with a registered
// occupancy count; a push into a full FIFO is accepted only alongside a pop.
module spi_word_fifo #(
  parameter int  WIDTH = 18,
  parameter int  DEPTH = 8,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/spi_relay_bridge.sv
// Sniffs words off the sensor SPI bus, buffers them and re-emits each as its
// own SPI-master frame. Define SPI_RELAY_CHTAG_EN to prefix frames with the channel.
module spi_relay_bridge
  import spi_relay_pkg::*;
#(
  parameter int  WORD_W     = 16,
  parameter int  NUM_CH     = 1,
  parameter int  FIFO_DEPTH = 8,
  parameter int  CLK_DIV    = 4,
  localparam int CH_W       = ch_width(NUM_CH),
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_sck,
  input  logic              in_cs_n,
  input  logic              in_miso,
  output logic              out_sck,
  output logic              out_cs_n,
  output logic              out_mosi,
  output logic [WORD_W-1:0] tap_data,
  output logic [CH_W-1:0]   tap_ch,
  output logic              tap_valid,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              ovf,
  output logic              frame_err,
  input  logic              err_clr
);

  localparam int ENTRY_W = WORD_W + CH_W;
`ifdef SPI_RELAY_CHTAG_EN
  localparam int TX_BITS = CH_W + WORD_W;
`else
  localparam int TX_BITS = WORD_W;
`endif
  localparam int BC_W   = $clog2(WORD_W);
  localparam int CNT_W  = $clog2(NUM_CH + 1);
  localparam int TMR_W  = $clog2(2 * CLK_DIV);
  localparam int BITS_W = $clog2(TX_BITS);

  // {sck, cs_n, miso} synchroniser chain plus {sck, cs_n} history for edges
  logic [2:0] sync_q [SYNC_DEPTH];
  logic [2:0] sync_d [SYNC_DEPTH];
  logic [1:0] hist_q, hist_d;
  logic       sck_s, cs_s, miso_s;
  logic       sck_rise, cs_fall, cs_rise;

  always_comb begin
    sync_d[0] = {in_sck, in_cs_n, in_miso};
    for (int i = 1; i < SYNC_DEPTH; i++) sync_d[i] = sync_q[i-1];
    hist_d = sync_q[SYNC_DEPTH-1][2:1];
  end

  assign sck_s    = sync_q[SYNC_DEPTH-1][2];
  assign cs_s     = sync_q[SYNC_DEPTH-1][1];
  assign miso_s   = sync_q[SYNC_DEPTH-1][0];
  assign sck_rise = sck_s & ~hist_q[1];
  assign cs_fall  = ~cs_s & hist_q[0];
  assign cs_rise  = cs_s & ~hist_q[0];

  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  ch_cnt_q, ch_cnt_d;
  logic [WORD_W-2:0] shift_q, shift_d;
  logic [WORD_W-1:0] tap_data_q, tap_data_d;
  logic [CH_W-1:0]   tap_ch_q, tap_ch_d;
  logic              tap_valid_q, tap_valid_d;
  logic              ovf_q, ovf_d;
  logic              frame_err_q, frame_err_d;
  logic [WORD_W-1:0] word_full;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic              frame_ev, ovf_ev;
  logic [ENTRY_W-1:0] fifo_rd;

  assign word_full = {shift_q, miso_s};

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    ch_cnt_d    = ch_cnt_q;
    shift_d     = shift_q;
    tap_data_d  = tap_data_q;
    tap_ch_d    = tap_ch_q;
    tap_valid_d = 1'b0;
    fifo_push   = 1'b0;
    frame_ev    = 1'b0;
    if (cs_fall) begin
      bit_cnt_d = '0;
      ch_cnt_d  = '0;
    end else if (cs_rise) begin
      frame_ev  = (bit_cnt_q != '0);
      bit_cnt_d = '0;
    end else if (sck_rise && !cs_s) begin
      shift_d = word_full[WORD_W-2:0];
      if (bit_cnt_q == BC_W'(WORD_W - 1)) begin
        bit_cnt_d = '0;
        // a word beyond the frame's channel count is flagged, never forwarded
        if (ch_cnt_q == CNT_W'(NUM_CH)) begin
          frame_ev = 1'b1;
        end else begin
          tap_data_d  = word_full;
          tap_ch_d    = ch_cnt_q[CH_W-1:0];
          tap_valid_d = 1'b1;
          fifo_push   = 1'b1;
          ch_cnt_d    = ch_cnt_q + CNT_W'(1);
        end
      end else begin
        bit_cnt_d = bit_cnt_q + BC_W'(1);
      end
    end
    ovf_ev      = fifo_push && fifo_full && !fifo_pop;
    ovf_d       = ovf_ev   ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    frame_err_d = frame_ev ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= 3'b010;
      hist_q      <= 2'b01;
      bit_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      shift_q     <= '0;
      tap_data_q  <= '0;
      tap_ch_q    <= '0;
      tap_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      hist_q      <= hist_d;
      bit_cnt_q   <= bit_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      shift_q     <= shift_d;
      tap_data_q  <= tap_data_d;
      tap_ch_q    <= tap_ch_d;
      tap_valid_q <= tap_valid_d;
      ovf_q       <= ovf_d;
      frame_err_q <= frame_err_d;
    end
  end

  spi_word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data ({ch_cnt_q[CH_W-1:0], word_full}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  logic [TX_BITS-1:0] tx_load;
`ifdef SPI_RELAY_CHTAG_EN
  assign tx_load = fifo_rd;
`else
  logic unused_ch;
  assign tx_load   = fifo_rd[WORD_W-1:0];
  assign unused_ch = ^fifo_rd[ENTRY_W-1:WORD_W];
`endif

  tx_state_t          tx_state_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [BITS_W-1:0]  bits_q;
  logic [TX_BITS-1:0] sr_q;
  logic               out_sck_q, out_cs_n_q, out_mosi_q;

  assign fifo_pop = (tx_state_q == TX_IDLE) && !fifo_empty;

  // every state dwells CLK_DIV cycles except GAP, which dwells twice that
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tmr_q      <= '0;
      bits_q     <= '0;
      sr_q       <= '0;
      out_sck_q  <= 1'b0;
      out_cs_n_q <= 1'b1;
      out_mosi_q <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (!fifo_empty) begin
            sr_q       <= tx_load;
            out_mosi_q <= tx_load[TX_BITS-1];
            out_cs_n_q <= 1'b0;
            tmr_q      <= TMR_W'(CLK_DIV - 1);
            bits_q     <= BITS_W'(TX_BITS - 1);
            tx_state_q <= TX_SETUP;
          end
        end
        TX_SETUP: begin
          if (tmr_q == '0) begin
            out_sck_q  <= 1'b1;
            tmr_q      <= TMR_W'(CLK_DIV - 1);
            tx_state_q <= TX_HI;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        TX_HI: begin
          if (tmr_q == '0) begin
            out_sck_q  <= 1'b0;
            sr_q       <= {sr_q[TX_BITS-2:0], 1'b0};
            out_mosi_q <= sr_q[TX_BITS-2];
            tmr_q      <= TMR_W'(CLK_DIV - 1);
            tx_state_q <= TX_LO;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        TX_LO: begin
          if (tmr_q == '0) begin
            tmr_q <= TMR_W'(CLK_DIV - 1);
            if (bits_q != '0) begin
              bits_q     <= bits_q - BITS_W'(1);
              out_sck_q  <= 1'b1;
              tx_state_q <= TX_HI;
            end else begin
              tx_state_q <= TX_HOLD;
            end
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        TX_HOLD: begin
          if (tmr_q == '0) begin
            out_cs_n_q <= 1'b1;
            tmr_q      <= TMR_W'(2 * CLK_DIV - 1);
            tx_state_q <= TX_GAP;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        TX_GAP: begin
          if (tmr_q == '0) tx_state_q <= TX_IDLE;
          else             tmr_q      <= tmr_q - TMR_W'(1);
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign out_sck   = out_sck_q;
  assign out_cs_n  = out_cs_n_q;
  assign out_mosi  = out_mosi_q;
  assign tap_data  = tap_data_q;
  assign tap_ch    = tap_ch_q;
  assign tap_valid = tap_valid_q;
  assign ovf       = ovf_q;
  assign frame_err = frame_err_q;

endmodule
